// File: rtl/cpu_pkg.sv
// Shared store-path definitions: size encodings, sequencer state type and size normalisation.
package cpu_pkg;

  localparam logic [1:0] SZ_WORD = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_BYTE = 2'b10;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    READ    = 2'b01,
    CAPTURE = 2'b10,
    WRITE   = 2'b11
  } state_t;

  // The unused size code 2'b11 behaves exactly like a word store.
  function automatic logic [1:0] norm_size(input logic [1:0] sz);
    return (sz == 2'b11) ? SZ_WORD : sz;
  endfunction

endpackage

// File: rtl/store_merge.sv
// Combinational lane merge of new store data into the captured memory word.
module store_merge
  import cpu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] data,
  input  logic [DATA_W-1:0] mdr,
  input  logic [1:0]        size,
  output logic [DATA_W-1:0] merged
);

  always_comb begin
    merged = data;
    case (size)
      SZ_HALF: merged = {data[15:0], mdr[15:0]};
      SZ_BYTE: merged = {data[7:0], mdr[23:0]};
      default: merged = data;
    endcase
  end

endmodule

// File: rtl/store_rmw_sequencer.sv
// Multicycle store controller: direct word writes, read-modify-write for halfword/byte.
// Optional misaligned-request detection is built when STORE_ALIGN_CHECK_EN is defined.
module store_rmw_sequencer
  import cpu_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_data,
  input  logic [1:0]        req_size,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int CNT_W = (MEM_LAT < 2) ? 1 : $clog2(MEM_LAT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MEM_LAT);

  state_t            state;
  state_t            state_n;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] mdr_q;
  logic [1:0]        size_q;
  logic [CNT_W-1:0]  cnt;
  logic              err_q;
  logic              accept;
  logic              misaligned;
  logic [DATA_W-1:0] merged;

  assign req_ready = reset && (state == IDLE);
  assign accept    = req_valid && req_ready;

`ifdef STORE_ALIGN_CHECK_EN
  always_comb begin
    misaligned = 1'b0;
    case (norm_size(req_size))
      SZ_WORD: misaligned = (req_addr[1:0] != 2'b00);
      SZ_HALF: misaligned = req_addr[0];
      default: misaligned = 1'b0;
    endcase
  end

  assign err = (state == WRITE) && err_q;
`else
  assign misaligned = 1'b0;
  assign err        = 1'b0;
`endif

  // cnt restarts at 1 whenever the sequencer is outside READ.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= IDLE;
      addr_q <= '0;
      data_q <= '0;
      size_q <= SZ_WORD;
      mdr_q  <= '0;
      cnt    <= '0;
      err_q  <= 1'b0;
    end else begin
      state <= state_n;
      if (accept) begin
        addr_q <= req_addr;
        data_q <= req_data;
        size_q <= norm_size(req_size);
        err_q  <= misaligned;
      end
      if (state == READ) cnt <= cnt + CNT_W'(1);
      else               cnt <= CNT_W'(1);
      if (state == CAPTURE) mdr_q <= mem_rdata;
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (misaligned || (norm_size(req_size) == SZ_WORD)) state_n = WRITE;
          else                                                state_n = READ;
        end
      end
      READ:    if (cnt == CNT_MAX) state_n = CAPTURE;
      CAPTURE: state_n = WRITE;
      WRITE:   state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // A misaligned request still spends its write cycle, but never touches memory.
  always_comb begin
    busy      = (state != IDLE);
    done      = (state == WRITE);
    mem_wr    = (state == WRITE) && !err_q;
    mem_addr  = addr_q;
    mem_wdata = merged;
  end

  store_merge #(.DATA_W(DATA_W)) u_merge (
    .data   (data_q),
    .mdr    (mdr_q),
    .size   (size_q),
    .merged (merged)
  );

endmodule

// File: tb/tb_store_rmw_sequencer.sv
// Self-checking bench for store_rmw_sequencer: vector table, hand corner sequences, random vs. transaction model.
module tb_store_rmw_sequencer;

  localparam int MEM_LAT = 1;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [31:0] req_data;
  logic [1:0]  req_size;
  logic [31:0] mem_addr;
  logic        mem_wr;
  logic [31:0] mem_rdata;
  logic [31:0] mem_wdata;
  logic        busy;
  logic        done;
  logic        err;

  logic [31:0] mem    [64];
  logic [31:0] refmem [64];
  logic        preload_en;
  logic [5:0]  preload_idx;
  logic [31:0] preload_val;

  int checks;
  int failures;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  size;
    logic [31:0] init;
    logic [31:0] exp_wdata;
    int          exp_wr_at;
  } vec_t;

  vec_t vecs[6];

  store_rmw_sequencer #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(MEM_LAT)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_size  (req_size),
    .mem_addr  (mem_addr),
    .mem_wr    (mem_wr),
    .mem_rdata (mem_rdata),
    .mem_wdata (mem_wdata),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Word-indexed memory with one cycle of read latency.
  always @(posedge clk) begin
    if (preload_en) mem[preload_idx] <= preload_val;
    else if (mem_wr) mem[mem_addr[7:2]] <= mem_wdata;
    mem_rdata <= mem[mem_addr[7:2]];
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
    req_valid = v;
    req_addr  = a;
    req_data  = d;
    req_size  = s;
  endtask

  task automatic preload(input int idx, input logic [31:0] val);
    @(negedge clk);
    preload_en  = 1'b1;
    preload_idx = idx[5:0];
    preload_val = val;
    refmem[idx] = val;
    @(negedge clk);
    preload_en  = 1'b0;
  endtask

  function automatic logic [31:0] model_merge(input logic [31:0] d, input logic [31:0] old, input logic [1:0] s);
    if (s == 2'b01) return ((d & 32'h0000_FFFF) << 16) | (old & 32'h0000_FFFF);
    if (s == 2'b10) return ((d & 32'h0000_00FF) << 24) | (old & 32'h00FF_FFFF);
    return d;
  endfunction

  initial begin
    int wr_at, nwr, acc2, ndone, k, wr_cycle, acc_cycle, idx;
    int wr_offs[2];
    logic [31:0] wdata_s, addr_s, done_s, exp_wdata, exp_addr, a, d;
    logic [1:0] s;
    logic sub, just_acc, exp_ready;

    checks = 0;
    failures = 0;
    reset = 1'b0;
    preload_en = 1'b0;
    preload_idx = '0;
    preload_val = '0;
    applyStimulus(1'b0, 32'h0, 32'h0, 2'b00);

    vecs[0] = '{32'h40, 32'hDEADBEEF, 2'b00, 32'h11223344, 32'hDEADBEEF, 1};
    vecs[1] = '{32'h40, 32'h0000ABCD, 2'b01, 32'h11223344, 32'hABCD3344, MEM_LAT + 2};
    vecs[2] = '{32'h40, 32'h000000EE, 2'b10, 32'h11223344, 32'hEE223344, MEM_LAT + 2};
    vecs[3] = '{32'h44, 32'h12345678, 2'b11, 32'hCAFEF00D, 32'h12345678, 1};
    vecs[4] = '{32'h48, 32'hFFFF1234, 2'b01, 32'h89ABCDEF, 32'h1234CDEF, MEM_LAT + 2};
    vecs[5] = '{32'h4C, 32'h123456A5, 2'b10, 32'h01020304, 32'hA5020304, MEM_LAT + 2};

    for (int i = 0; i < 64; i++) preload(i, $urandom);

    @(negedge clk);
    checkOutput("rst_mem_wr", mem_wr, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_err", err, 0);
    checkOutput("rst_ready", req_ready, 0);
    checkOutput("rst_mem_addr", mem_addr, 0);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("rst_release_ready", req_ready, 1);

    for (int v = 0; v < 6; v++) begin
      idx = int'(vecs[v].addr[7:2]);
      preload(idx, vecs[v].init);
      @(negedge clk);
      checkOutput($sformatf("tbl%0d_ready", v), req_ready, 1);
      applyStimulus(1'b1, vecs[v].addr, vecs[v].data, vecs[v].size);
      wr_at = -1; nwr = 0; wdata_s = '0; addr_s = '0; done_s = '0;
      for (int off = 1; off <= 6; off++) begin
        @(negedge clk);
        if (off == 1) applyStimulus(1'b0, 32'h0, 32'h0, 2'b00);
        if (mem_wr) begin
          nwr++;
          wr_at = off;
          wdata_s = mem_wdata;
          addr_s = mem_addr;
          done_s = {31'b0, done};
        end
        if (off <= vecs[v].exp_wr_at) checkOutput($sformatf("tbl%0d_busy_ready", v), req_ready, 0);
      end
      checkOutput($sformatf("tbl%0d_write_cycle", v), 32'(wr_at), 32'(vecs[v].exp_wr_at));
      checkOutput($sformatf("tbl%0d_write_count", v), 32'(nwr), 1);
      checkOutput($sformatf("tbl%0d_wdata", v), wdata_s, vecs[v].exp_wdata);
      checkOutput($sformatf("tbl%0d_addr", v), addr_s, vecs[v].addr);
      checkOutput($sformatf("tbl%0d_done", v), done_s, 1);
      checkOutput($sformatf("tbl%0d_memory", v), mem[idx], vecs[v].exp_wdata);
      refmem[idx] = vecs[v].exp_wdata;
    end

    // Reset asserted while the read is outstanding must suppress the write.
    preload(32, 32'h55AA55AA);
    @(negedge clk);
    applyStimulus(1'b1, 32'h80, 32'h00005555, 2'b01);
    @(negedge clk);
    applyStimulus(1'b0, 32'h0, 32'h0, 2'b00);
    checkOutput("midrst_busy", busy, 1);
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checkOutput("midrst_mem_wr", mem_wr, 0);
      checkOutput("midrst_busy_low", busy, 0);
      checkOutput("midrst_done", done, 0);
      checkOutput("midrst_ready", req_ready, 0);
      checkOutput("midrst_mem_addr", mem_addr, 0);
      checkOutput("midrst_wdata", mem_wdata, 0);
    end
    reset = 1'b1;
    #1;
    checkOutput("midrst_release_ready", req_ready, 1);
    @(negedge clk);
    checkOutput("midrst_memory", mem[32], refmem[32]);

    // Two halfword requests with req_valid held continuously.
    preload(40, 32'hA0A0A0A0);
    preload(41, 32'hA4A4A4A4);
    @(negedge clk);
    checkOutput("b2b_ready_first", req_ready, 1);
    applyStimulus(1'b1, 32'hA0, 32'h1111BEEF, 2'b01);
    acc2 = -1; nwr = 0; ndone = 0; wr_offs[0] = -1; wr_offs[1] = -1;
    for (int off = 1; off <= 10; off++) begin
      @(negedge clk);
      if (done) ndone++;
      if (mem_wr) begin
        if (nwr < 2) wr_offs[nwr] = off;
        if (nwr == 0) checkOutput("b2b_wdata1", mem_wdata, 32'hBEEFA0A0);
        else          checkOutput("b2b_wdata2", mem_wdata, 32'hCAFEA4A4);
        nwr++;
      end
      if (off == 1) applyStimulus(1'b1, 32'hA4, 32'h2222CAFE, 2'b01);
      else if (acc2 >= 0) applyStimulus(1'b0, 32'h0, 32'h0, 2'b00);
      else if (req_ready) acc2 = off;
    end
    checkOutput("b2b_accept2", 32'(acc2), MEM_LAT + 3);
    checkOutput("b2b_write1", 32'(wr_offs[0]), MEM_LAT + 2);
    checkOutput("b2b_write2", 32'(wr_offs[1]), 2 * MEM_LAT + 5);
    checkOutput("b2b_writes", 32'(nwr), 2);
    checkOutput("b2b_dones", 32'(ndone), 2);
    refmem[40] = 32'hBEEFA0A0;
    refmem[41] = 32'hCAFEA4A4;

`ifdef STORE_ALIGN_CHECK_EN
    preload(16, 32'h11223344);
    for (int m = 0; m < 2; m++) begin
      @(negedge clk);
      if (m == 0) applyStimulus(1'b1, 32'h41, 32'h0000ABCD, 2'b01);
      else        applyStimulus(1'b1, 32'h42, 32'h0BADF00D, 2'b00);
      @(negedge clk);
      applyStimulus(1'b0, 32'h0, 32'h0, 2'b00);
      checkOutput("align_err", err, 1);
      checkOutput("align_done", done, 1);
      checkOutput("align_mem_wr", mem_wr, 0);
      @(negedge clk);
      checkOutput("align_err_clear", err, 0);
      checkOutput("align_ready", req_ready, 1);
      checkOutput("align_memory", mem[16], 32'h11223344);
    end
`else
    preload(16, 32'h11223344);
    @(negedge clk);
    applyStimulus(1'b1, 32'h41, 32'h0000ABCD, 2'b01);
    @(negedge clk);
    applyStimulus(1'b0, 32'h0, 32'h0, 2'b00);
    checkOutput("unaligned_err", err, 0);
    checkOutput("unaligned_no_early_write", mem_wr, 0);
    repeat (MEM_LAT + 1) @(negedge clk);
    checkOutput("unaligned_mem_wr", mem_wr, 1);
    checkOutput("unaligned_wdata", mem_wdata, 32'hABCD3344);
    checkOutput("unaligned_addr", mem_addr, 32'h41);
    refmem[16] = 32'hABCD3344;
`endif

    // Random traffic checked cycle by cycle against a transaction-level model.
    @(negedge clk);
    @(negedge clk);
    wr_cycle = -1; acc_cycle = -100; sub = 1'b0; just_acc = 1'b0;
    exp_wdata = '0; exp_addr = '0;
    for (k = 0; k < 420; k++) begin
      @(negedge clk);
      exp_ready = (k > wr_cycle);
      checkOutput("rnd_ready", req_ready, {31'b0, exp_ready});
      checkOutput("rnd_busy", busy, {31'b0, !exp_ready});
      checkOutput("rnd_mem_wr", mem_wr, (k == wr_cycle) ? 1 : 0);
      checkOutput("rnd_done", done, (k == wr_cycle) ? 1 : 0);
      checkOutput("rnd_err", err, 0);
      if (k == wr_cycle) begin
        checkOutput("rnd_wdata", mem_wdata, exp_wdata);
        checkOutput("rnd_waddr", mem_addr, exp_addr);
        refmem[exp_addr[7:2]] = exp_wdata;
      end
      if (sub && k > acc_cycle && k <= acc_cycle + MEM_LAT)
        checkOutput("rnd_raddr", mem_addr, exp_addr);
      if (just_acc) applyStimulus(1'b0, 32'h0, 32'h0, 2'b00);
      just_acc = 1'b0;
      if (!req_valid && k < 400 && $urandom_range(0, 2) == 0) begin
        a = 32'($urandom_range(0, 255));
        d = $urandom;
        s = 2'($urandom_range(0, 3));
`ifdef STORE_ALIGN_CHECK_EN
        if (s == 2'b00 || s == 2'b11) a = a & 32'hFFFF_FFFC;
        else if (s == 2'b01)          a = a & 32'hFFFF_FFFE;
`endif
        applyStimulus(1'b1, a, d, s);
      end
      if (req_valid && exp_ready) begin
        s = (req_size == 2'b11) ? 2'b00 : req_size;
        acc_cycle = k;
        sub = (s != 2'b00);
        wr_cycle = k + (sub ? MEM_LAT + 2 : 1);
        exp_addr = req_addr;
        exp_wdata = model_merge(req_data, refmem[req_addr[7:2]], s);
        just_acc = 1'b1;
      end
    end

    @(negedge clk);
    for (int i = 0; i < 64; i++) checkOutput($sformatf("final_mem%0d", i), mem[i], refmem[i]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
